uart_tx_controller: RTL and testbench
=====================================

# uart_tx_controller

UART transmitter for the peripheral UART controller: accepts parallel bytes through a valid/ready handshake, buffers them in a small FIFO and serialises each as a start bit, LSB-first data bits and stop bit(s) at the configured baud rate. It is the transmit half of the UART controller. It sits next to `uart_rx_controller` on the same 16 MHz clock, and its `serial_out` drives the UART TX pin directly or the RX controller in loopback benches.

## Interface
- `F_CLK`, 16000000, system clock frequency in Hz.
- `TX_BAUD_RATE`, 115200, line rate in bit/s.
- `CLKS_PER_BIT`, (F_CLK + TX_BAUD_RATE/2) / TX_BAUD_RATE = 139, clocks per bit, rounded to nearest. Elaboration error if less than 2.
- `DATA_WIDTH`, 8, data bits per frame.
- `STOP_BITS`, 1, number of stop bits. Only 1 or 2 is legal.
- `FIFO_DEPTH`, 4, transmit FIFO entries. Must be a power of two and at least 2.
- `clk_16mhz`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  byte to transmit.
- `tx_valid`  in  1  `data_in` is valid.
- `tx_ready`  out  1  FIFO can accept; equals `fifo_count != FIFO_DEPTH`.
- `serial_out`  out  1  UART line, idle high, registered.
- `tx_start_pulse`  out  1  one-cycle pulse when a start bit begins.
- `tx_done_pulse`  out  1  one-cycle pulse when the last stop bit completes.
- `tx_busy`  out  1  high when the FSM is not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.

## Operation
- A push happens at the rising edge where `tx_valid && tx_ready` is true. `data_in` is written at the tail. A push while full is impossible because `tx_ready` is 0, and `tx_valid` with `tx_ready` low is ignored.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: `serial_out` = 1. If `fifo_count != 0`, pop the head into the shift register, go to START, drive `serial_out` = 0 and pulse `tx_start_pulse`.
  - START: lasts CLKS_PER_BIT cycles, then go to DATA and drive `shift[0]`.
  - DATA: each bit lasts CLKS_PER_BIT cycles, shifting right. After bit DATA_WIDTH-1, go to STOP and drive `serial_out` = 1.
  - STOP: lasts STOP_BITS × CLKS_PER_BIT cycles, then pulse `tx_done_pulse`.
    - If the FIFO is non-empty on that edge, pop, go to START and pulse `tx_start_pulse` on the same edge (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- The baud counter (0..CLKS_PER_BIT-1) and the bit counter are cleared on every state entry. There is no free-running baud tick, so every bit is exactly CLKS_PER_BIT cycles.
- A simultaneous push and pop leaves `fifo_count` unchanged. A pop always takes the oldest entry.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. `fifo_count` is tracked separately.

## Timing
- Reset values:
  - `serial_out` = 1, `tx_ready` = 1, `tx_busy` = 0.
  - `tx_start_pulse` = 0, `tx_done_pulse` = 0, `fifo_count` = 0.
  - FSM in IDLE, FIFO empty.
- Reset mid-frame:
  - `serial_out` returns to 1 asynchronously and the FIFO is flushed.
  - No `tx_done_pulse` is emitted.
- Latency: a push at edge N into an empty FIFO in IDLE gives a `serial_out` fall and `tx_start_pulse` at edge N+1.
- Frame length is (1 + DATA_WIDTH + STOP_BITS) × CLKS_PER_BIT cycles. The default is 1390 cycles (86.875 µs).
- `tx_done_pulse` asserts at edge S + frame length, where S is the start edge.
- `tx_busy` rises with `tx_start_pulse`. It falls on the edge that returns the FSM to IDLE.
- The pulses are single-cycle registered outputs.

## Test plan
- Reset: hold `rst` for 10 cycles. Require every output at its reset value and `serial_out` = 1 for 100 cycles after release.
- Single byte 0xA5:
  - `tx_start_pulse` occurs 1 cycle after the push.
  - `serial_out` levels, each 139 cycles: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done_pulse` occurs exactly 1390 cycles after the start.
- Burst: push 0x00–0x05 on consecutive cycles with FIFO_DEPTH = 4.
  - 0x00 is popped after one cycle, so 0x01–0x04 fill the FIFO.
  - `tx_ready` = 0 on the 0x05 cycle; 0x05 is not accepted.
  - Frames are back-to-back; `tx_start_pulse` and `tx_done_pulse` coincide between frames.
- Loopback into `uart_rx_controller` at BAUD_115200: send 0xDB down to 0x01. Each `rx_done_pulse` must show a matching `data_out`, and `rx_error` must never assert.
- Reset mid-frame:
  - Assert `rst` during data bit 3. `serial_out` = 1 with no clock edge and `fifo_count` = 0.
  - A subsequent 0x3C must be received correctly.
- STOP_BITS = 2 with byte 0xFF: frame length 1529 cycles, and the line is high for 2 × 139 cycles before `tx_done_pulse`.

Source files
------------

// File: rtl/uart_tx_controller_if.sv
// rtl/uart_tx_controller_if.sv - byte handshake between a producer and the UART transmitter
//
// Purpose: carries one byte per accepted handshake into uart_tx_controller.
// Signals:
//   data_in   byte to transmit, valid while tx_valid is high
//   tx_valid  producer offers data_in
//   tx_ready  transmitter FIFO has room; a byte moves when tx_valid && tx_ready
// Modports:
//   master  producer side (drives data_in/tx_valid)
//   slave   transmitter side (drives tx_ready)
interface uart_tx_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output data_in,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  data_in,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - UART transmitter with a small input FIFO
//
// Purpose: buffers bytes from the handshake interface and serialises each as
// one start bit, DATA_WIDTH data bits LSB first and STOP_BITS stop bits, every
// bit lasting exactly CLKS_PER_BIT clocks. Frames run back to back while the
// FIFO holds data.
// Ports:
//   clk_16mhz       system clock, rising edge
//   rst             asynchronous active-high reset
//   tx              slave side of uart_tx_controller_if (data_in, tx_valid, tx_ready)
//   serial_out      registered UART line, idle high
//   tx_start_pulse  one cycle, registered, as a start bit begins
//   tx_done_pulse   one cycle, registered, as the last stop bit completes
//   tx_busy         FSM not in IDLE
//   fifo_count      occupied FIFO entries
module uart_tx_controller #(
  parameter int F_CLK        = 16000000,
  parameter int TX_BAUD_RATE = 115200,
  parameter int CLKS_PER_BIT = (F_CLK + TX_BAUD_RATE / 2) / TX_BAUD_RATE,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk_16mhz,
  input  logic                             rst,
  uart_tx_controller_if.slave              tx,
  output logic                             serial_out,
  output logic                             tx_start_pulse,
  output logic                             tx_done_pulse,
  output logic                             tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign tx.tx_ready = (fifo_count != FCNT_W'(FIFO_DEPTH));
  assign push        = tx.tx_valid && tx.tx_ready;
  assign head        = mem[rd_ptr];

  // Pointers wrap on their own width; the count is kept separately so that
  // full and empty stay distinguishable.
  always_ff @(posedge clk_16mhz or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (push) mem[wr_ptr] <= tx.data_in;
  end

  // ---------------------------------------------------------------- FSM
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      baud_cnt;
  logic [CNT_W-1:0]      baud_cnt_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  serial_next;
  logic                  start_next;
  logic                  done_next;
  logic                  bit_end;

  assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clk_16mhz or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      serial_out     <= 1'b1;
      tx_start_pulse <= 1'b0;
      tx_done_pulse  <= 1'b0;
    end else begin
      state          <= state_next;
      baud_cnt       <= baud_cnt_next;
      bit_cnt        <= bit_cnt_next;
      shift          <= shift_next;
      serial_out     <= serial_next;
      tx_start_pulse <= start_next;
      tx_done_pulse  <= done_next;
    end
  end

  // All outputs are computed one edge ahead so the line and pulses come
  // straight out of flops.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt + 1'b1;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    serial_next   = serial_out;
    start_next    = 1'b0;
    done_next     = 1'b0;
    pop           = 1'b0;

    case (state)
      IDLE: begin
        serial_next   = 1'b1;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        if (fifo_count != '0) begin
          pop         = 1'b1;
          shift_next  = head;
          state_next  = START;
          serial_next = 1'b0;
          start_next  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_next    = DATA;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          serial_next   = shift[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            state_next   = STOP;
            bit_cnt_next = '0;
            serial_next  = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
            shift_next   = shift >> 1;
            serial_next  = shift_next[0];
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            done_next    = 1'b1;
            bit_cnt_next = '0;
            // A waiting byte starts on the same edge: no idle gap between frames.
            if (fifo_count != '0) begin
              pop         = 1'b1;
              shift_next  = head;
              state_next  = START;
              serial_next = 1'b0;
              start_next  = 1'b1;
            end else begin
              state_next  = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - self-checking bench for uart_tx_controller
module tb_uart_tx_controller;

  localparam int C0    = 139;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FCW   = 3;
  localparam int FL0   = (1 + DW + 1) * C0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- DUTs
  uart_tx_controller_if #(.DATA_WIDTH(DW)) if0 ();
  uart_tx_controller_if #(.DATA_WIDTH(DW)) if1 ();

  logic           ser0, sp0, dp0, busy0;
  logic [FCW-1:0] cnt0;
  logic           ser1, sp1, dp1, busy1;
  logic [FCW-1:0] cnt1;

  uart_tx_controller dut0 (
    .clk_16mhz      (clk),
    .rst            (rst),
    .tx             (if0.slave),
    .serial_out     (ser0),
    .tx_start_pulse (sp0),
    .tx_done_pulse  (dp0),
    .tx_busy        (busy0),
    .fifo_count     (cnt0)
  );

  uart_tx_controller #(.STOP_BITS(2)) dut1 (
    .clk_16mhz      (clk),
    .rst            (rst),
    .tx             (if1.slave),
    .serial_out     (ser1),
    .tx_start_pulse (sp1),
    .tx_done_pulse  (dp1),
    .tx_busy        (busy1),
    .fifo_count     (cnt1)
  );

  // ---------------------------------------------------------------- model
  // Frame-level view: a queue of accepted bytes, and for the frame on the
  // line only its byte and how many edges have passed since its start.
  logic [7:0] q[$];
  logic [7:0] sent_q[$];
  bit         m_busy;
  int         m_pos;
  logic [7:0] m_byte;
  bit         m_start, m_done, m_can_push;
  bit         cmp_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      sent_q.delete();
      m_busy  = 1'b0;
      m_pos   = 0;
      m_start = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_can_push = (q.size() != DEPTH);
      m_start    = 1'b0;
      m_done     = 1'b0;
      if (m_busy) begin
        m_pos++;
        if (m_pos == FL0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (!m_busy && q.size() != 0) begin
        m_byte  = q.pop_front();
        m_busy  = 1'b1;
        m_pos   = 0;
        m_start = 1'b1;
        sent_q.push_back(m_byte);
      end
      if (if0.tx_valid && m_can_push) q.push_back(if0.data_in);
    end
  end

  function automatic logic exp_serial();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_pos / C0;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return m_byte[idx-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [FCW+4:0] exp_v, act_v;
    if (cmp_en) begin
      exp_v = {exp_serial(), m_start, m_done, m_busy, FCW'(q.size()), (q.size() != DEPTH)};
      act_v = {ser0, sp0, dp0, busy0, cnt0, if0.tx_ready};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual ser/start/done/busy/count/ready=%b/%b/%b/%b/%0d/%b required=%b/%b/%b/%b/%0d/%b",
                 $time, ser0, sp0, dp0, busy0, cnt0, if0.tx_ready,
                 exp_v[FCW+4], exp_v[FCW+3], exp_v[FCW+2], exp_v[FCW+1], exp_v[FCW:1], exp_v[0]);
      end
    end
  end

  int coincide = 0;
  always @(negedge clk) if (sp0 && dp0) coincide++;

  // ---------------------------------------------------------------- line decoder
  // Independent receiver sampling mid-bit; checks bytes arrive in push order
  // with a valid start and stop bit.
  bit         rx_abort = 1'b0;
  logic [7:0] rx_b;
  logic [7:0] rx_exp;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] rx_log[$];
  logic       st_ok, sp_ok;

  always @(posedge rst) rx_abort = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst && ser0 === 1'b0) begin
        rx_abort = 1'b0;
        repeat (C0 / 2) @(negedge clk);
        st_ok = (ser0 === 1'b0);
        for (int i = 0; i < DW; i++) begin
          repeat (C0) @(negedge clk);
          rx_b[i] = ser0;
        end
        repeat (C0) @(negedge clk);
        sp_ok = (ser0 === 1'b1);
        if (!rx_abort) begin
          checks++;
          if (sent_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected actual=%h required=no frame", rx_b);
          end else begin
            rx_exp = sent_q.pop_front();
            if (rx_b !== rx_exp || !st_ok || !sp_ok) begin
              errors++;
              $display("FAIL rx_byte actual=%h start_ok=%b stop_ok=%b required=%h start_ok=1 stop_ok=1",
                       rx_b, st_ok, sp_ok, rx_exp);
            end
          end
          rx_log.push_back(rx_b);
          last_rx = rx_b;
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy0 || cnt0 != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (busy0 || cnt0 != 0) ? 1 : 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic       levels [FL0];
  logic [7:0] frame_a5;
  int         t, done_t, extra_starts, lows, run, base, n;

  initial begin
    if0.tx_valid = 1'b0; if0.data_in = '0;
    if1.tx_valid = 1'b0; if1.data_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;

    // reset
    repeat (10) @(negedge clk);
    check("reset_serial", ser0, 1);
    check("reset_ready", if0.tx_ready, 1);
    check("reset_busy", busy0, 0);
    check("reset_pulses", {sp0, dp0}, 0);
    check("reset_count", cnt0, 0);
    rst = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser0 !== 1'b1 || busy0) lows++;
    end
    check("post_reset_idle", lows, 0);

    // single byte 0xA5
    if0.data_in = 8'hA5; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    check("a5_no_start_yet", sp0, 0);
    @(negedge clk);
    check("a5_start_latency", sp0, 1);
    done_t = -1; extra_starts = 0;
    for (int k = 0; k <= FL0; k++) begin
      if (k < FL0) levels[k] = ser0;
      if (k > 0 && sp0) extra_starts++;
      if (dp0 && done_t < 0) done_t = k;
      if (k < FL0) @(negedge clk);
    end
    check("a5_done_time", done_t, FL0);
    check("a5_extra_starts", extra_starts, 0);
    frame_a5 = 8'hA5;
    for (int b = 0; b < 10; b++) begin
      int bad;
      logic lvl;
      bad = 0;
      lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : frame_a5[b-1];
      for (int k = b * C0; k < (b + 1) * C0; k++) if (levels[k] !== lvl) bad++;
      check($sformatf("a5_bit%0d_level%0d", b, lvl), bad, 0);
    end
    wait_idle(200);

    // burst 0x00..0x05
    coincide = 0;
    base = rx_log.size();
    if0.data_in = 8'h00; if0.tx_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if0.data_in = 8'(i);
    end
    check("burst_ready_on_05", if0.tx_ready, 0);
    check("burst_count_full", cnt0, 4);
    @(negedge clk);
    if0.tx_valid = 1'b0;
    wait_idle(6 * FL0);
    check("burst_coincide", coincide, 4);
    check("burst_rx_count", rx_log.size() - base, 5);
    for (int i = 0; i < 5 && base + i < rx_log.size(); i++)
      check($sformatf("burst_rx%0d", i), rx_log[base+i], i);

    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      if0.tx_valid = ($urandom_range(0, 3) == 0);
      if0.data_in  = 8'($urandom);
      @(negedge clk);
    end
    if0.tx_valid = 1'b0;
    wait_idle(6 * FL0);

    // reset during data bit 3
    if0.data_in = 8'h96; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    n = 0;
    while (!sp0 && n < 10) begin @(negedge clk); n++; end
    check("mid_start_seen", sp0, 1);
    if0.data_in = 8'h11; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.data_in = 8'h22;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    repeat (4 * C0 + 70 - 2) @(negedge clk);
    check("mid_bit3_low", ser0, 0);
    check("mid_fifo_loaded", cnt0, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_async_serial", ser0, 1);
    check("mid_async_count", cnt0, 0);
    check("mid_async_busy", busy0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    check("mid_no_done", dp0, 0);
    base = rx_log.size();
    if0.data_in = 8'h3C; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    n = 0;
    while (rx_log.size() == base && n < 2 * FL0) begin @(negedge clk); n++; end
    check("after_reset_rx", last_rx, 8'h3C);
    wait_idle(2 * FL0);

    // two stop bits, 0xFF
    if1.data_in = 8'hFF; if1.tx_valid = 1'b1;
    @(negedge clk);
    if1.tx_valid = 1'b0;
    n = 0;
    while (!sp1 && n < 5) begin @(negedge clk); n++; end
    check("stop2_start_seen", sp1, 1);
    t = 0; run = 0; lows = (ser1 == 1'b0) ? 1 : 0;
    while (t < 2000) begin
      @(negedge clk);
      t++;
      if (dp1) break;
      if (ser1) run++;
      else begin run = 0; lows++; end
    end
    check("stop2_frame_len", t, 1529);
    check("stop2_high_before_done", run, 1390);
    check("stop2_start_low", lows, 139);
    n = 0;
    while (busy1 && n < 10) begin @(negedge clk); n++; end
    check("stop2_idle", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
